sram_arbiter: RTL and testbench
===============================

// Module: sram_arbiter
// PURPOSE
// Shares the single external 128Kx8 async SRAM between the CPU bus and a DMA/video requester.
// Sequences each access with a fixed address-setup / strobe / recovery timing.
// Applies the CPU page-window mapping. Registers all SRAM control outputs.
// Sits between the CPU bus decoder / DMA engine and the SRAM pins.
// PARAMETERS
// STROBE_CYCLES  2  clocks OE_n/WE_n held low per access (>=1)
// DMA_MAX_WAIT   3  consecutive DMA losses after which DMA wins the next arbitration (>=1)
// PORTS
// clk         in   1   system clock
// rst         in   1   synchronous reset, active-high
// cpu_req     in   1   CPU access request; held until cpu_ready
// cpu_rw      in   1   1=read, 0=write
// cpu_ad      in   16  CPU address
// cpu_di      in   8   CPU write data
// cpu_do      out  8   CPU read data, valid with cpu_ready, held until next CPU read
// cpu_ready   out  1   one-cycle completion pulse for CPU access
// page        in   5   [3]=window enable, [2:0]=bank, [4]=window write-protect
// dma_req     in   1   DMA request; held until dma_ack
// dma_we      in   1   1=write, 0=read
// dma_ad      in   17  DMA physical address (unmapped)
// dma_di      in   8   DMA write data
// dma_do      out  8   DMA read data, valid with dma_ack, held until next DMA read
// dma_ack     out  1   one-cycle completion pulse for DMA access
// SRAM_AD     out  17  SRAM address (registered)
// SRAM_DQ     inout 8  SRAM data bus
// SRAM_WE_n   out  1   write strobe, active-low (registered)
// SRAM_OE_n   out  1   output enable, active-low (registered)
// SRAM_CS2    out  1   chip select, active-high (registered)
// BEHAVIOUR
// - Reset: state IDLE, SRAM_WE_n=1, SRAM_OE_n=1, SRAM_CS2=0, SRAM_AD=0, SRAM_DQ=Z,
//   cpu_ready=0, dma_ack=0, cpu_do=0, dma_do=0, dma_wait counter=0.
// - Reset mid-access aborts the access: strobes high and DQ released at the next edge; no ready/ack pulse.
// - FSM: IDLE -> ADDR (1 clk) -> STROBE (STROBE_CYCLES clk) -> RECOVER (1 clk) -> IDLE.
// - IDLE: arbitrate among requests sampled at the edge.
//   Latch owner, rw, mapped address and write data; later requester changes are ignored.
// - Arbitration: a single requester always wins. When both request, CPU wins
//   unless dma_wait==DMA_MAX_WAIT. dma_wait increments when DMA loses, clears when DMA granted.
// - CPU mapping, evaluated at grant: win = page[3] & cpu_ad[15:13]==3'b110 & ~(page[4] & ~cpu_rw).
//   SRAM_AD = win ? {1'b1,page[2:0],cpu_ad[12:0]} : {1'b0,cpu_ad}.
//   A write into the window with page[4]=1 therefore goes to the low bank (unmapped).
// - ADDR: SRAM_AD and SRAM_CS2=1 are valid. On a write, DQ is driven from ADDR through RECOVER.
// - STROBE: on a read OE_n=0; on a write WE_n=0; never both.
//   Read data is captured into cpu_do/dma_do at the edge ending the last STROBE cycle.
// - RECOVER: strobes high, address and data held. The owner's ready/ack is high for exactly this cycle.
// - Latency: 2+STROBE_CYCLES clocks from the sampling edge to the ready/ack cycle.
//   Throughput: one access per 3+STROBE_CYCLES clocks.
// - CS2 is dropped in IDLE. DQ is tri-stated in IDLE and on reads.
// - If req drops before completion, the access still finishes and the pulse is still emitted.
// - A requester must not re-raise req in the ready/ack cycle expecting a new access without first
//   seeing one IDLE cycle. A held req is treated as a new request in IDLE.
// STRUCTURE
// - Package sram_pkg: FSM state encoding, SRAM_AW=17, PAGE_WINDOW=3'b110, owner encoding.
// - Sub-module sram_page_map: combinational CPU address/page -> 17-bit physical address.
// - The FSM, arbiter, counter and output registers live in this module.
// TESTING
// 1. CPU read 0x1234, page=0, DQ model returns 0xA5 -> SRAM_AD=0x01234, OE_n low 2 clks,
//    cpu_ready pulses 4 clks after sample, cpu_do=0xA5.
// 2. CPU write 0xC010 data 0x3C, page=5'b01011 -> SRAM_AD=0x16010, WE_n low 2 clks, DQ=0x3C ADDR..RECOVER.
//    Same write with page=5'b11011 -> SRAM_AD=0x0C010.
// 3. cpu_req and dma_req held high continuously -> grant order CPU,CPU,CPU,DMA repeating (DMA_MAX_WAIT=3).
//    Exactly one pulse per access.
// 4. DMA write 0x1FFFF data 0xFF then read back -> SRAM_AD=0x1FFFF unmapped, dma_do=0xFF.
// 5. rst asserted during STROBE of a write -> next edge WE_n=1, CS2=0, DQ=Z, no cpu_ready.
//    After release, a new request completes normally.
// 6. cpu_req dropped one cycle after grant -> access completes and cpu_ready still pulses once.
//    OE_n and WE_n never low in the same cycle (assertion over all tests).

Source files
------------

// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM arbiter slice: access FSM state encoding,
// SRAM geometry, the CPU page-window constant, owner encoding, and the
// CPU window-hit rule used by the page mapper.
package sram_pkg;

  localparam int SRAM_AW = 17;
  localparam logic [2:0] PAGE_WINDOW = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ADDR    = 2'd1,
    ST_STROBE  = 2'd2,
    ST_RECOVER = 2'd3
  } state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_t;

  // True when a CPU access is redirected into the banked upper 64K.
  // A write with the window write-protect set falls through to the low bank.
  function automatic logic window_hit(input logic [15:0] cpu_ad,
                                      input logic [4:0]  page,
                                      input logic        cpu_rw);
    return page[3] & (cpu_ad[15:13] == PAGE_WINDOW) & ~(page[4] & ~cpu_rw);
  endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester-side bus of the SRAM arbiter: CPU port (with page register) and
// DMA/video port.
//   master : the requesters (CPU bus decoder, DMA engine)
//   slave  : the arbiter
// cpu_ready / dma_ack are single-cycle completion pulses; cpu_do / dma_do
// hold the last read data of their owner.
interface sram_arbiter_if;
  import sram_pkg::*;

  logic                cpu_req;
  logic                cpu_rw;
  logic [15:0]         cpu_ad;
  logic [7:0]          cpu_di;
  logic [7:0]          cpu_do;
  logic                cpu_ready;
  logic [4:0]          page;
  logic                dma_req;
  logic                dma_we;
  logic [SRAM_AW-1:0]  dma_ad;
  logic [7:0]          dma_di;
  logic [7:0]          dma_do;
  logic                dma_ack;

  modport master (
    output cpu_req, cpu_rw, cpu_ad, cpu_di, page,
    output dma_req, dma_we, dma_ad, dma_di,
    input  cpu_do, cpu_ready, dma_do, dma_ack
  );

  modport slave (
    input  cpu_req, cpu_rw, cpu_ad, cpu_di, page,
    input  dma_req, dma_we, dma_ad, dma_di,
    output cpu_do, cpu_ready, dma_do, dma_ack
  );

endinterface

// File: rtl/sram_page_map.sv
// Combinational CPU address translation.
//   cpu_ad  : 16-bit CPU address
//   page    : [3] window enable, [2:0] bank, [4] window write-protect
//   cpu_rw  : 1=read, 0=write
//   phys_ad : 17-bit SRAM address
// Window hits land in the upper 64K as {1, bank, offset}; everything else is
// the CPU address in the lower 64K.
module sram_page_map
  import sram_pkg::*;
(
  input  logic [15:0]        cpu_ad,
  input  logic [4:0]         page,
  input  logic               cpu_rw,
  output logic [SRAM_AW-1:0] phys_ad
);

  // Select banked or flat physical address.
  always_comb begin
    phys_ad = {1'b0, cpu_ad};
    if (window_hit(cpu_ad, page, cpu_rw)) begin
      phys_ad = {1'b1, page[2:0], cpu_ad[12:0]};
    end else begin
      phys_ad = {1'b0, cpu_ad};
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one external 128Kx8 async SRAM between the CPU and a DMA/video
// requester. Each access runs ADDR (1 clk) -> STROBE (STROBE_CYCLES clk) ->
// RECOVER (1 clk) -> IDLE, with every SRAM control pin driven from a flop.
//   clk, rst  : clock, synchronous active-high reset
//   bus       : requester bus (sram_arbiter_if.slave)
//   SRAM_AD   : registered SRAM address
//   SRAM_DQ   : SRAM data, driven ADDR..RECOVER on writes, tri-stated otherwise
//   SRAM_WE_n : registered write strobe (active-low)
//   SRAM_OE_n : registered output enable (active-low)
//   SRAM_CS2  : registered chip select (active-high), low in IDLE
module sram_arbiter
  import sram_pkg::*;
#(
  parameter int STROBE_CYCLES = 2,
  parameter int DMA_MAX_WAIT  = 3
)
(
  input  logic               clk,
  input  logic               rst,
  sram_arbiter_if.slave      bus,
  output logic [SRAM_AW-1:0] SRAM_AD,
  inout  wire  [7:0]         SRAM_DQ,
  output logic               SRAM_WE_n,
  output logic               SRAM_OE_n,
  output logic               SRAM_CS2
);

  localparam int SCW = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
  localparam int WW  = $clog2(DMA_MAX_WAIT + 1);
  localparam logic [SCW-1:0] STROBE_LAST = SCW'(STROBE_CYCLES - 1);
  localparam logic [WW-1:0]  WAIT_MAX    = WW'(DMA_MAX_WAIT);

  state_t             state_r;
  owner_t             owner_r;
  logic               rd_r;
  logic [SCW-1:0]     strobe_cnt_r;
  logic [WW-1:0]      dma_wait_r;
  logic [SRAM_AW-1:0] sram_ad_r;
  logic               sram_we_n_r;
  logic               sram_oe_n_r;
  logic               sram_cs2_r;
  logic               dq_oe_r;
  logic [7:0]         dq_out_r;
  logic [7:0]         cpu_do_r;
  logic [7:0]         dma_do_r;
  logic               cpu_ready_r;
  logic               dma_ack_r;
  logic [SRAM_AW-1:0] cpu_phys_s;
  logic               dma_grant_s;

  sram_page_map u_page_map (
    .cpu_ad  (bus.cpu_ad),
    .page    (bus.page),
    .cpu_rw  (bus.cpu_rw),
    .phys_ad (cpu_phys_s)
  );

  // DMA wins when alone, or when it has lost DMA_MAX_WAIT contests in a row.
  always_comb begin
    dma_grant_s = 1'b0;
    if (bus.dma_req) begin
      if (!bus.cpu_req) begin
        dma_grant_s = 1'b1;
      end else if (dma_wait_r == WAIT_MAX) begin
        dma_grant_s = 1'b1;
      end else begin
        dma_grant_s = 1'b0;
      end
    end else begin
      dma_grant_s = 1'b0;
    end
  end

  // Access FSM, arbiter, starvation counter and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      owner_r      <= OWN_CPU;
      rd_r         <= 1'b1;
      strobe_cnt_r <= '0;
      dma_wait_r   <= '0;
      sram_ad_r    <= '0;
      sram_we_n_r  <= 1'b1;
      sram_oe_n_r  <= 1'b1;
      sram_cs2_r   <= 1'b0;
      dq_oe_r      <= 1'b0;
      dq_out_r     <= 8'h00;
      cpu_do_r     <= 8'h00;
      dma_do_r     <= 8'h00;
      cpu_ready_r  <= 1'b0;
      dma_ack_r    <= 1'b0;
    end else begin
      cpu_ready_r <= 1'b0;
      dma_ack_r   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          sram_cs2_r  <= 1'b0;
          sram_we_n_r <= 1'b1;
          sram_oe_n_r <= 1'b1;
          dq_oe_r     <= 1'b0;
          if (bus.cpu_req || bus.dma_req) begin
            state_r    <= ST_ADDR;
            sram_cs2_r <= 1'b1;
            if (dma_grant_s) begin
              owner_r    <= OWN_DMA;
              rd_r       <= ~bus.dma_we;
              sram_ad_r  <= bus.dma_ad;
              dq_out_r   <= bus.dma_di;
              dq_oe_r    <= bus.dma_we;
              dma_wait_r <= '0;
            end else begin
              owner_r   <= OWN_CPU;
              rd_r      <= bus.cpu_rw;
              sram_ad_r <= cpu_phys_s;
              dq_out_r  <= bus.cpu_di;
              dq_oe_r   <= ~bus.cpu_rw;
              // Counter never passes WAIT_MAX: at WAIT_MAX a contending DMA wins.
              if (bus.dma_req) begin
                dma_wait_r <= dma_wait_r + WW'(1);
              end
            end
          end
        end
        ST_ADDR: begin
          state_r      <= ST_STROBE;
          strobe_cnt_r <= '0;
          sram_oe_n_r  <= ~rd_r;
          sram_we_n_r  <= rd_r;
        end
        ST_STROBE: begin
          if (strobe_cnt_r == STROBE_LAST) begin
            state_r     <= ST_RECOVER;
            sram_oe_n_r <= 1'b1;
            sram_we_n_r <= 1'b1;
            // OE_n is still low up to this edge, so DQ carries SRAM data.
            if (rd_r && (owner_r == OWN_CPU)) begin
              cpu_do_r <= SRAM_DQ;
            end
            if (rd_r && (owner_r == OWN_DMA)) begin
              dma_do_r <= SRAM_DQ;
            end
            if (owner_r == OWN_CPU) begin
              cpu_ready_r <= 1'b1;
            end else begin
              dma_ack_r <= 1'b1;
            end
          end else begin
            strobe_cnt_r <= strobe_cnt_r + SCW'(1);
          end
        end
        ST_RECOVER: begin
          state_r    <= ST_IDLE;
          sram_cs2_r <= 1'b0;
          dq_oe_r    <= 1'b0;
        end
        default: begin
          state_r     <= ST_IDLE;
          sram_we_n_r <= 1'b1;
          sram_oe_n_r <= 1'b1;
          sram_cs2_r  <= 1'b0;
          dq_oe_r     <= 1'b0;
        end
      endcase
    end
  end

  assign SRAM_AD   = sram_ad_r;
  assign SRAM_WE_n = sram_we_n_r;
  assign SRAM_OE_n = sram_oe_n_r;
  assign SRAM_CS2  = sram_cs2_r;
  assign SRAM_DQ   = dq_oe_r ? dq_out_r : 8'bzzzz_zzzz;

  assign bus.cpu_do    = cpu_do_r;
  assign bus.dma_do    = dma_do_r;
  assign bus.cpu_ready = cpu_ready_r;
  assign bus.dma_ack   = dma_ack_r;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: behavioural SRAM on the pins, a reference memory and
// address-map model kept separately, directed steps followed by random traffic.
module tb_sram_arbiter;
  import sram_pkg::*;

  localparam int S   = 2;
  localparam int MAX = 3;

  logic        clk;
  logic        rst;
  logic [16:0] sram_ad;
  wire  [7:0]  sram_dq;
  logic        sram_we_n;
  logic        sram_oe_n;
  logic        sram_cs2;

  int tests = 0;
  int fails = 0;
  int dma_losses = 0;
  bit excl_on = 1'b0;

  logic [7:0] sram_mem [0:131071];
  logic [7:0] mem_ref  [0:131071];
  bit         mem_init_done = 1'b0;

  sram_arbiter_if bus_if ();

  sram_arbiter #(.STROBE_CYCLES(S), .DMA_MAX_WAIT(MAX)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_if),
    .SRAM_AD   (sram_ad),
    .SRAM_DQ   (sram_dq),
    .SRAM_WE_n (sram_we_n),
    .SRAM_OE_n (sram_oe_n),
    .SRAM_CS2  (sram_cs2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Async SRAM model: drives DQ while selected and output-enabled.
  assign sram_dq = (!sram_oe_n && sram_cs2 && sram_we_n) ? sram_mem[sram_ad] : 8'bzzzz_zzzz;

  // SRAM model storage; first edge loads the background pattern.
  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 131072; i++) sram_mem[i] = 8'((i * 37) + 11);
      sram_mem[17'h01234] = 8'hA5;
      mem_init_done = 1'b1;
    end else if (!sram_we_n && sram_cs2) begin
      sram_mem[sram_ad] = sram_dq;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // OE_n and WE_n must never be low together.
  always @(negedge clk) begin
    if (excl_on) check("oe_we_excl", {31'd0, (sram_oe_n | sram_we_n)}, 32'd1);
  end

  // Reference CPU address map, computed arithmetically.
  function automatic logic [16:0] map_ref(input logic [15:0] a, input logic [4:0] pg, input bit rd);
    int phys;
    if (pg[3] && (a >= 16'hC000) && (a < 16'hE000) && !(pg[4] && !rd))
      phys = 32'h10000 + (int'(pg[2:0]) * 32'h2000) + (int'(a) - 32'hC000);
    else
      phys = int'(a);
    return phys[16:0];
  endfunction

  task automatic drive_cpu(input bit rd, input logic [15:0] a, input logic [7:0] d, input logic [4:0] pg);
    bus_if.cpu_req = 1'b1; bus_if.cpu_rw = rd; bus_if.cpu_ad = a; bus_if.cpu_di = d; bus_if.page = pg;
  endtask

  task automatic drive_dma(input bit rd, input logic [16:0] a, input logic [7:0] d);
    bus_if.dma_req = 1'b1; bus_if.dma_we = ~rd; bus_if.dma_ad = a; bus_if.dma_di = d;
  endtask

  // One isolated access, checked for latency, address, strobe widths, DQ, pulses.
  task automatic access(input bit is_dma, input bit rd, input logic [16:0] ad, input logic [7:0] di,
                        input logic [4:0] pg, input bit drop_early, input logic [16:0] exp_ad,
                        input string tag);
    int n; int oe_cnt; int we_cnt; bit seen; bit dq_ok; bit other; logic [16:0] ad_seen; logic cs_seen;
    @(negedge clk);
    if (is_dma) drive_dma(rd, ad, di); else drive_cpu(rd, ad[15:0], di, pg);
    @(posedge clk);
    n = 0; oe_cnt = 0; we_cnt = 0; seen = 1'b0; dq_ok = 1'b1; other = 1'b0; ad_seen = '0; cs_seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        ad_seen = sram_ad; cs_seen = sram_cs2;
        if (drop_early) begin bus_if.cpu_req = 1'b0; bus_if.dma_req = 1'b0; end
      end
      if (!sram_oe_n) oe_cnt++;
      if (!sram_we_n) we_cnt++;
      if (!rd && (sram_dq !== di)) dq_ok = 1'b0;
      if (is_dma ? bus_if.cpu_ready : bus_if.dma_ack) other = 1'b1;
      seen = is_dma ? bus_if.dma_ack : bus_if.cpu_ready;
    end
    check({tag, "_latency"}, n, 2 + S);
    check({tag, "_addr"}, {15'd0, ad_seen}, {15'd0, exp_ad});
    check({tag, "_cs2"}, {31'd0, cs_seen}, 32'd1);
    check({tag, "_oe_cycles"}, oe_cnt, rd ? S : 0);
    check({tag, "_we_cycles"}, we_cnt, rd ? 0 : S);
    check({tag, "_dq_drive"}, {31'd0, dq_ok}, 32'd1);
    check({tag, "_other_pulse"}, {31'd0, other}, 32'd0);
    if (rd) begin
      if (is_dma) check({tag, "_dma_do"}, {24'd0, bus_if.dma_do}, {24'd0, mem_ref[exp_ad]});
      else        check({tag, "_cpu_do"}, {24'd0, bus_if.cpu_do}, {24'd0, mem_ref[exp_ad]});
    end else begin
      mem_ref[exp_ad] = di;
    end
    bus_if.cpu_req = 1'b0; bus_if.dma_req = 1'b0;
    @(negedge clk);
    check({tag, "_one_pulse"}, {30'd0, bus_if.cpu_ready, bus_if.dma_ack}, 32'd0);
    check({tag, "_idle_cs2"}, {31'd0, sram_cs2}, 32'd0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int cyc; int k; int last; int nserve; int n; bit got; bit exp_dma;
    bit order [2];
    bit c_rd; bit d_rd; logic [15:0] c_ad; logic [16:0] d_ad; logic [7:0] c_di; logic [7:0] d_di;
    logic [4:0] c_pg; logic [16:0] c_phys; int mode;

    for (int i = 0; i < 131072; i++) mem_ref[i] = 8'((i * 37) + 11);
    mem_ref[17'h01234] = 8'hA5;

    bus_if.cpu_req = 1'b0; bus_if.cpu_rw = 1'b1; bus_if.cpu_ad = 16'h0000; bus_if.cpu_di = 8'h00;
    bus_if.page = 5'b00000; bus_if.dma_req = 1'b0; bus_if.dma_we = 1'b0; bus_if.dma_ad = 17'h00000;
    bus_if.dma_di = 8'h00;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_we_n", {31'd0, sram_we_n}, 32'd1);
    check("rst_oe_n", {31'd0, sram_oe_n}, 32'd1);
    check("rst_cs2", {31'd0, sram_cs2}, 32'd0);
    check("rst_ad", {15'd0, sram_ad}, 32'd0);
    check("rst_pulses", {30'd0, bus_if.cpu_ready, bus_if.dma_ack}, 32'd0);
    check("rst_do", {16'd0, bus_if.cpu_do, bus_if.dma_do}, 32'd0);
    rst = 1'b0;
    excl_on = 1'b1;

    // 1: CPU read, flat map.
    access(1'b0, 1'b1, 17'h01234, 8'h00, 5'b00000, 1'b0, 17'h01234, "t1_cpu_rd");
    // 2: CPU write through the window, then the same write write-protected.
    access(1'b0, 1'b0, 17'h0C010, 8'h3C, 5'b01011, 1'b0, 17'h16010, "t2_win_wr");
    access(1'b0, 1'b0, 17'h0C010, 8'h3C, 5'b11011, 1'b0, 17'h0C010, "t2_wp_wr");
    access(1'b0, 1'b1, 17'h0C010, 8'h00, 5'b11011, 1'b0, 17'h16010, "t2_wp_rd");
    // 4: DMA write top address, read back.
    access(1'b1, 1'b0, 17'h1FFFF, 8'hFF, 5'b00000, 1'b0, 17'h1FFFF, "t4_dma_wr");
    access(1'b1, 1'b1, 17'h1FFFF, 8'h00, 5'b00000, 1'b0, 17'h1FFFF, "t4_dma_rd");

    // 3: both requesters held; CPU,CPU,CPU,DMA pattern at one access per 3+S clocks.
    @(negedge clk);
    drive_cpu(1'b1, 16'h0100, 8'h00, 5'b00000);
    drive_dma(1'b1, 17'h00200, 8'h00);
    cyc = 0; k = 0; last = -1;
    while (k < 8 && cyc < 8 * (3 + S) + 20) begin
      @(negedge clk);
      cyc++;
      if (bus_if.cpu_ready || bus_if.dma_ack) begin
        exp_dma = (dma_losses == MAX);
        if (exp_dma) dma_losses = 0; else dma_losses++;
        check("t3_owner", {31'd0, bus_if.dma_ack}, {31'd0, exp_dma});
        check("t3_single", {31'd0, bus_if.cpu_ready & bus_if.dma_ack}, 32'd0);
        if (exp_dma) check("t3_dma_do", {24'd0, bus_if.dma_do}, {24'd0, mem_ref[17'h00200]});
        else         check("t3_cpu_do", {24'd0, bus_if.cpu_do}, {24'd0, mem_ref[17'h00100]});
        if (last >= 0) check("t3_interval", cyc - last, 3 + S);
        last = cyc;
        k++;
        if (k == 8) begin bus_if.cpu_req = 1'b0; bus_if.dma_req = 1'b0; end
      end
    end
    check("t3_count", k, 8);
    bus_if.cpu_req = 1'b0; bus_if.dma_req = 1'b0;
    @(negedge clk);

    // 5: reset during STROBE of a write aborts it without a ready pulse.
    @(negedge clk);
    drive_cpu(1'b0, 16'h0300, 8'h5A, 5'b00000);
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    check("t5_in_strobe", {31'd0, sram_we_n}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    bus_if.cpu_req = 1'b0;
    mem_ref[17'h00300] = 8'h5A;
    dma_losses = 0;
    check("t5_we_n", {31'd0, sram_we_n}, 32'd1);
    check("t5_oe_n", {31'd0, sram_oe_n}, 32'd1);
    check("t5_cs2", {31'd0, sram_cs2}, 32'd0);
    check("t5_no_ready", {31'd0, bus_if.cpu_ready}, 32'd0);
    @(negedge clk);
    check("t5_no_ready2", {31'd0, bus_if.cpu_ready}, 32'd0);
    rst = 1'b0;
    access(1'b0, 1'b1, 17'h00300, 8'h00, 5'b00000, 1'b0, 17'h00300, "t5_after");

    // 6: request dropped right after grant still completes with one pulse.
    access(1'b0, 1'b1, 17'h00456, 8'h00, 5'b00000, 1'b1, 17'h00456, "t6_drop");
    access(1'b1, 1'b0, 17'h10456, 8'h77, 5'b00000, 1'b1, 17'h10456, "t6_dma_drop");

    // Random traffic: CPU only, DMA only, or both raised together.
    for (int r = 0; r < 40; r++) begin
      mode = $urandom_range(0, 2);
      c_rd = 1'($urandom_range(0, 1));
      d_rd = 1'($urandom_range(0, 1));
      c_pg = 5'($urandom);
      c_ad = ($urandom_range(0, 1) == 1) ? (16'hC000 | 16'($urandom_range(0, 16'h1FFF))) : 16'($urandom);
      d_ad = 17'($urandom);
      c_di = 8'($urandom);
      d_di = 8'($urandom);
      c_phys = map_ref(c_ad, c_pg, c_rd);
      nserve = (mode == 2) ? 2 : 1;
      order[0] = (mode == 1); order[1] = 1'b1;
      if (mode == 2 && dma_losses == MAX) begin order[0] = 1'b1; order[1] = 1'b0; end
      if (mode != 1) drive_cpu(c_rd, c_ad, c_di, c_pg);
      if (mode != 0) drive_dma(d_rd, d_ad, d_di);
      for (int j = 0; j < nserve; j++) begin
        if (order[j]) dma_losses = 0;
        else if (nserve == 2) dma_losses++;
        got = 1'b0; n = 0;
        while (!got && n < 3 * (3 + S)) begin
          @(negedge clk);
          n++;
          got = bus_if.cpu_ready | bus_if.dma_ack;
        end
        check("rnd_pulse", {31'd0, got}, 32'd1);
        check("rnd_owner", {30'd0, bus_if.cpu_ready, bus_if.dma_ack}, order[j] ? 32'd1 : 32'd2);
        if (order[j]) begin
          check("rnd_dma_addr", {15'd0, sram_ad}, {15'd0, d_ad});
          if (d_rd) check("rnd_dma_do", {24'd0, bus_if.dma_do}, {24'd0, mem_ref[d_ad]});
          else mem_ref[d_ad] = d_di;
          bus_if.dma_req = 1'b0;
        end else begin
          check("rnd_cpu_addr", {15'd0, sram_ad}, {15'd0, c_phys});
          if (c_rd) check("rnd_cpu_do", {24'd0, bus_if.cpu_do}, {24'd0, mem_ref[c_phys]});
          else mem_ref[c_phys] = c_di;
          bus_if.cpu_req = 1'b0;
        end
      end
      @(negedge clk);
      check("rnd_idle", {30'd0, bus_if.cpu_ready, bus_if.dma_ack}, 32'd0);
    end

    excl_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
